hamming_window: RTL and testbench
=================================

HAMMING_WINDOW -- requirements
Module: hamming_window

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, giving the sample width in bits.
REQ-002 SHALL have parameter NUM_COEFFICIENTS, default 400, giving the frame length and window length N.
REQ-003 SHALL have parameter NFFT_SIZE, default 512, giving the FFT size; frame_ptr_o width is $clog2(NFFT_SIZE).
REQ-004 SHALL provide the ports below; one clock; reset is asynchronous and active-low:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse, start windowing a frame
valid_to_read_i  in  1  window buffer has a sample available
rd_en_o  out  1  one-cycle read request to the window buffer
frame_ptr_o  out  $clog2(NFFT_SIZE)  index n of the current output sample
frame_sample_i  in  SAMPLE_WIDTH  signed sample; valid the cycle after rd_en_o
hamming_sample_o  out  SAMPLE_WIDTH  signed windowed sample
out_valid_o  out  1  hamming_sample_o and frame_ptr_o valid this cycle
done_o  out  1  one-cycle pulse after the frame completes

Function
REQ-005 SHALL hold a ROM of N signed Q1.15 coefficients c[n] = round(32767*(0.54 - 0.46*cos(2*pi*n/(N-1)))), n = 0..N-1, fixed at elaboration.
REQ-006 SHALL use a state machine with states IDLE, REQ, WAIT, MULT, OUT, DONE, and a sample index idx.
REQ-007 IDLE: on start_i = 1, SHALL clear idx to 0 and go to REQ; otherwise SHALL stay in IDLE.
REQ-008 start_i SHALL be ignored in every state other than IDLE.
REQ-009 REQ: rd_en_o SHALL equal (state==REQ && valid_to_read_i), combinationally.
REQ-010 REQ: on a cycle where rd_en_o is 1, SHALL go to WAIT; while valid_to_read_i is 0, SHALL stay in REQ indefinitely with rd_en_o = 0.
REQ-011 WAIT: SHALL register frame_sample_i, then go to MULT.
REQ-012 MULT: SHALL register the full 2*SAMPLE_WIDTH-bit signed product sample*c[idx], then go to OUT.
REQ-013 OUT: SHALL drive hamming_sample_o = product >>> 15 (arithmetic shift, floor), truncated to SAMPLE_WIDTH bits, with frame_ptr_o = idx and out_valid_o = 1 for exactly this one cycle.
REQ-014 Leaving OUT: if idx == N-1, SHALL go to DONE; otherwise SHALL increment idx and go to REQ.
REQ-015 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-016 Per frame, SHALL produce exactly N out_valid_o pulses with frame_ptr_o = 0..N-1 ascending, and exactly N rd_en_o pulses.
REQ-017 SHALL not zero-pad indices N..NFFT_SIZE-1; the downstream block fills them.
REQ-018 Minimum spacing between consecutive out_valid_o pulses SHALL be 4 cycles.
REQ-019 Outside OUT, hamming_sample_o and frame_ptr_o SHALL hold their last values.
REQ-020 out_valid_o SHALL be 0 in every state other than OUT; done_o SHALL be 0 in every state other than DONE; rd_en_o SHALL be 0 in every state other than REQ.

Reset
REQ-021 While rst_n = 0: state SHALL be IDLE, idx 0, and rd_en_o, out_valid_o, done_o, frame_ptr_o and hamming_sample_o SHALL all be 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; after release the block SHALL stay in IDLE until the next start_i.

Verification
REQ-023 Constant input 0x4000 with valid_to_read_i = 1, then pulse start_i -> out[0] = 1310, out[199] = 16383, 400 out_valid_o pulses with frame_ptr_o 0..399, then one done_o pulse.
REQ-024 Constant input -16384 -> out[0] = -1311, confirming floor rounding; out[n] == out[399-n] for all n.
REQ-025 valid_to_read_i held 0 for 50 cycles after start_i -> no rd_en_o and no out_valid_o; on raising valid_to_read_i, the first rd_en_o occurs in that same cycle.
REQ-026 start_i pulsed again mid-frame -> ignored; the frame completes normally with exactly 400 outputs.
REQ-027 rst_n pulsed low at sample 100 -> all outputs 0 and no done_o; a following start_i -> full 400-sample frame from frame_ptr_o = 0.
REQ-028 Input 0x7FFF -> out[199] = 32766; all outputs within the signed 16-bit range.

Source files
------------

// File: rtl/hamming_window.sv
// Hamming window stage: reads one frame of N samples from a window buffer and multiplies
// each sample by a Q1.15 Hamming coefficient taken from an elaboration-time ROM.
//
// Ports:
//   clk               clock, all state on rising edge
//   rst_n             asynchronous active-low reset
//   start_i           one-cycle pulse, start windowing a frame (honoured only when idle)
//   valid_to_read_i   window buffer has a sample available
//   rd_en_o           one-cycle read request to the window buffer (combinational)
//   frame_ptr_o       index n of the current output sample
//   frame_sample_i    signed sample, valid the cycle after rd_en_o
//   hamming_sample_o  signed windowed sample, (sample * c[n]) >>> 15
//   out_valid_o       hamming_sample_o / frame_ptr_o valid this cycle
//   done_o            one-cycle pulse after the last sample of the frame
//
// Per sample the FSM walks REQ -> WAIT -> MULT -> OUT, so outputs are at least 4 cycles
// apart. Indices N..NFFT_SIZE-1 are not produced; the downstream block zero-fills them.
module hamming_window #(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned NUM_COEFFICIENTS = 400,
  parameter int unsigned NFFT_SIZE        = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        valid_to_read_i,
  output logic                        rd_en_o,
  output logic [$clog2(NFFT_SIZE)-1:0] frame_ptr_o,
  input  logic [SAMPLE_WIDTH-1:0]     frame_sample_i,
  output logic [SAMPLE_WIDTH-1:0]     hamming_sample_o,
  output logic                        out_valid_o,
  output logic                        done_o
);

  localparam int unsigned CoefW = 16;
  localparam int unsigned ProdW = SAMPLE_WIDTH + CoefW;
  localparam int unsigned PtrW  = $clog2(NFFT_SIZE);
  localparam int unsigned IdxW  = $clog2(NUM_COEFFICIENTS);
  localparam real         Pi    = 3.14159265358979323846;

  // c[n] = round(32767 * (0.54 - 0.46 * cos(2*pi*n/(N-1)))); always positive, so +0.5
  // followed by truncation is round-to-nearest.
  function automatic logic [CoefW-1:0] calc_coef(input int n);
    real w;
    w = 0.54 - 0.46 * $cos(2.0 * Pi * real'(n) / real'(NUM_COEFFICIENTS - 1));
    return CoefW'($rtoi(32767.0 * w + 0.5));
  endfunction

  // Coefficient ROM, constant-folded at elaboration.
  logic [CoefW-1:0] coef_rom [NUM_COEFFICIENTS];

  for (genvar g = 0; g < NUM_COEFFICIENTS; g++) begin : gen_rom
    localparam logic [CoefW-1:0] Coef = calc_coef(g);
    assign coef_rom[g] = Coef;
  end

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StMult,
    StOut,
    StDone
  } state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           idx_q;
  logic [SAMPLE_WIDTH-1:0]   sample_q;
  logic signed [ProdW-1:0]   product_q;
  logic [PtrW-1:0]           ptr_q;
  logic                      out_valid_q;
  logic                      done_q;

  // Both operands sign-extended to the full product width before multiplying.
  logic signed [ProdW-1:0]   sample_ext;
  logic signed [ProdW-1:0]   coef_ext;
  logic signed [ProdW-1:0]   product_d;

  assign sample_ext = ProdW'($signed(sample_q));
  assign coef_ext   = ProdW'($signed(coef_rom[idx_q]));
  assign product_d  = sample_ext * coef_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      sample_q    <= '0;
      product_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          // Same condition as rd_en_o: the read is issued in this cycle.
          if (valid_to_read_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          sample_q <= frame_sample_i;
          state_q  <= StMult;
        end
        StMult: begin
          // Product and pointer land together so both are valid throughout StOut.
          product_q   <= product_d;
          ptr_q       <= PtrW'(idx_q);
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (idx_q == IdxW'(NUM_COEFFICIENTS - 1)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StReq;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_en_o     = (state_q == StReq) && valid_to_read_i;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign frame_ptr_o = ptr_q;

  // Arithmetic shift right by 15 (floor) then truncate: just a slice of the product.
  // product_q only changes in StMult, so the output holds its value outside StOut.
  assign hamming_sample_o = product_q[15 +: SAMPLE_WIDTH];

  // Bits below the Q15 point and the redundant top sign bit are discarded by design.
  logic unused_product_bits;
  assign unused_product_bits = ^{product_q[ProdW-1], product_q[14:0]};

endmodule

// File: tb/tb_hamming_window.sv
module tb_hamming_window;

  localparam int N = 400;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        valid_to_read_i;
  logic        rd_en_o;
  logic [8:0]  frame_ptr_o;
  logic [15:0] frame_sample_i;
  logic [15:0] hamming_sample_o;
  logic        out_valid_o;
  logic        done_o;

  hamming_window #(
    .SAMPLE_WIDTH    (16),
    .NUM_COEFFICIENTS(N),
    .NFFT_SIZE       (512)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .valid_to_read_i (valid_to_read_i),
    .rd_en_o         (rd_en_o),
    .frame_ptr_o     (frame_ptr_o),
    .frame_sample_i  (frame_sample_i),
    .hamming_sample_o(hamming_sample_o),
    .out_valid_o     (out_valid_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ptr;
    bit chk;
    int val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   out_arr [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output beat.
  initial begin
    exp_t e;
    int   v;
    forever begin
      @(negedge clk);
      if (rd_en_o) rd_cnt++;
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        out_cnt++;
        v = int'($signed(hamming_sample_o));
        if (int'(frame_ptr_o) < N) out_arr[frame_ptr_o] = v;
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("frame_ptr", int'(frame_ptr_o), e.ptr);
          if (e.chk) chk($sformatf("sample[%0d]", e.ptr), v, e.val);
        end
      end
    end
  end

  // Hand-computed values: e0 = out[0] = out[399], e1 = out[1] = out[398],
  // e199 = out[199] = out[200] (window is symmetric).
  task automatic push_frame(input int e0, input int e1, input int e199);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.ptr = n;
      e.chk = 1'b1;
      if (n == 0 || n == N - 1)        e.val = e0;
      else if (n == 1 || n == N - 2)   e.val = e1;
      else if (n == 199 || n == 200)   e.val = e199;
      else                             e.chk = 1'b0;
      if (!e.chk) e.val = 0;
      sb_q.push_back(e);
    end
  endtask

  task automatic clear_counts();
    out_cnt  = 0;
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_out_count"}, out_cnt, N);
    chk({tag, "_rd_count"}, rd_cnt, N);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  task automatic wait_outputs(input int target);
    for (int i = 0; i < 3000 && out_cnt < target; i++) @(posedge clk);
    chk("reached_output_count", (out_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en_o), 0);
    chk({tag, "_out_valid"}, int'(out_valid_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_frame_ptr"}, int'(frame_ptr_o), 0);
    chk({tag, "_sample"}, int'(hamming_sample_o), 0);
  endtask

  initial begin
    int bad;
    rst_n           = 1'b0;
    start_i         = 1'b0;
    valid_to_read_i = 1'b1;
    frame_sample_i  = 16'h4000;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("idle_no_read", rd_cnt, 0);

    // Frame A: +0.5 full scale.
    clear_counts();
    push_frame(1310, 1311, 16383);
    pulse_start();
    wait_done("frame_a");

    // Frame B: -0.5 full scale; floor rounding and symmetry.
    frame_sample_i = 16'hC000;
    clear_counts();
    push_frame(-1311, -1312, -16384);
    pulse_start();
    wait_done("frame_b");
    bad = 0;
    for (int n = 0; n < N; n++) if (out_arr[n] != out_arr[N - 1 - n]) bad++;
    chk("symmetry_violations", bad, 0);

    // Frame C: maximum positive input.
    frame_sample_i = 16'h7FFF;
    clear_counts();
    push_frame(2620, 2622, 32766);
    pulse_start();
    wait_done("frame_c");
    bad = 0;
    for (int n = 0; n < N; n++) if (out_arr[n] <= 0 || out_arr[n] > 32766) bad++;
    chk("max_input_range", bad, 0);

    // Stall for 50 cycles, then a stray start pulse mid-frame.
    frame_sample_i  = 16'h4000;
    valid_to_read_i = 1'b0;
    clear_counts();
    push_frame(1310, 1311, 16383);
    pulse_start();
    repeat (50) @(posedge clk);
    chk("stall_rd_count", rd_cnt, 0);
    chk("stall_out_count", out_cnt, 0);
    #1 valid_to_read_i = 1'b1;
    #3 chk("rd_en_same_cycle", int'(rd_en_o), 1);
    wait_outputs(200);
    pulse_start();
    wait_done("stall_restart");

    // Reset at sample 100 aborts the frame.
    clear_counts();
    push_frame(1310, 1311, 16383);
    pulse_start();
    wait_outputs(100);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    sb_q.delete();
    repeat (3) @(posedge clk);
    chk("midreset_no_done", done_cnt, 0);
    #1 rst_n = 1'b1;
    clear_counts();
    repeat (20) @(posedge clk);
    chk("post_reset_idle_rd", rd_cnt, 0);
    chk("post_reset_idle_out", out_cnt, 0);

    clear_counts();
    push_frame(1310, 1311, 16383);
    pulse_start();
    wait_done("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
